// File: rtl/acl_pkg.sv
// ADXL362 command set, register map and sequencer state codes
// shared by the accelerometer SPI controller and its byte shifter.
package acl_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h0A;
    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] REG_XDATA  = 8'h08;
    localparam logic [7:0] REG_FILTER = 8'h2C;
    localparam logic [7:0] REG_POWER  = 8'h2D;
    localparam logic [7:0] FILTER_VAL = 8'h13;
    localparam logic [7:0] POWER_VAL  = 8'h02;

    localparam logic [2:0] ST_PWRUP  = 3'd0;
    localparam logic [2:0] ST_WR_FLT = 3'd1;
    localparam logic [2:0] ST_GAP1   = 3'd2;
    localparam logic [2:0] ST_WR_PWR = 3'd3;
    localparam logic [2:0] ST_GAP2   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_READ   = 3'd6;

    // Byte idx of the frame sent while in transaction state st.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] st,
        input logic [2:0] idx
    );
        logic [7:0] b;
        b = 8'h00;
        case (st)
            ST_WR_FLT: b = (idx == 3'd0) ? CMD_WRITE :
                           (idx == 3'd1) ? REG_FILTER : FILTER_VAL;
            ST_WR_PWR: b = (idx == 3'd0) ? CMD_WRITE :
                           (idx == 3'd1) ? REG_POWER : POWER_VAL;
            ST_READ:   b = (idx == 3'd0) ? CMD_READ :
                           (idx == 3'd1) ? REG_XDATA : 8'h00;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: low half-period, then 8 high/low SCLK pulses.
// A start coincident with done chains the next byte with no SCLK gap.
module spi_byte_shifter #(
    parameter int SCLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx,
    output logic       sclk,
    output logic       mosi
);

    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

    logic       busy_q, busy_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hp_q, hp_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic [7:0] txs_q, txs_d;
    logic [7:0] rx_q, rx_d;
    logic       last_half;

    assign last_half = (cnt_q == DIV_LAST);
    assign done      = busy_q && last_half && (hp_q == 4'd15);
    assign busy      = busy_q;
    assign rx        = rx_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hp_d   = hp_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        txs_d  = txs_q;
        rx_d   = rx_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = 8'd0;
            hp_d   = 4'd0;
            sclk_d = 1'b0;
            mosi_d = tx[7];
            txs_d  = {tx[6:0], 1'b0};
        end else if (busy_q) begin
            if (!last_half) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd0;
                if (hp_q == 4'd15) begin
                    busy_d = 1'b0;
                    sclk_d = 1'b0;
                end else begin
                    hp_d = hp_q + 4'd1;
                    // even half-periods are low: their end is a rising edge
                    if (!hp_q[0]) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end else begin
                        sclk_d = 1'b0;
                        mosi_d = txs_q[7];
                        txs_d  = {txs_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= 8'd0;
            hp_q   <= 4'd0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            txs_q  <= 8'd0;
            rx_q   <= 8'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            txs_q  <= txs_d;
            rx_q   <= rx_d;
        end
    end

endmodule

// File: rtl/acl_spi_ctrl.sv
// ADXL362 sequencer: power-up wait, filter/power config writes, then
// periodic X/Y/Z burst reads published with a one-cycle valid strobe.
module acl_spi_ctrl
    import acl_pkg::*;
#(
    parameter int SCLK_DIV      = 50,
    parameter int PWRUP_CYCLES  = 1000000,
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int CS_GAP        = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HOLD,
    input  logic       ACL_MISO,
    output logic       ACL_SCLK,
    output logic       ACL_MOSI,
    output logic       ACL_CSN,
    output logic [7:0] ACC_X,
    output logic [7:0] ACC_Y,
    output logic [7:0] ACC_Z,
    output logic       DATA_VALID,
    output logic       CFG_DONE
);

    localparam int CMAX = (PWRUP_CYCLES > SAMPLE_PERIOD) ?
                          PWRUP_CYCLES : SAMPLE_PERIOD;
    localparam int CW = $clog2(CMAX + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [CW-1:0] PW_LAST  = CW'(PWRUP_CYCLES - 1);
    localparam logic [CW-1:0] SP_LAST  = CW'(SAMPLE_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [7:0]    DIV_LAST = 8'(SCLK_DIV - 1);

    logic [2:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    bidx_q, bidx_d;
    logic          tail_q, tail_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          csn_q, csn_d;
    logic          cfg_q, cfg_d;
    logic          dv_q, dv_d;
    logic [7:0]    ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic [7:0]    sx_q, sx_d, sy_q, sy_d;

    logic       sh_start, sh_busy, sh_done;
    logic [7:0] sh_tx, sh_rx;
    logic [2:0] tx_st, tx_idx, last_byte;
    logic       launch, idle_ok;

    assign idle_ok = (gap_q == GAP_LAST) && !sh_busy;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        gap_d  = gap_q;
        bidx_d = bidx_q;
        tail_d = tail_q;
        tcnt_d = tcnt_q;
        csn_d  = csn_q;
        cfg_d  = cfg_q;
        dv_d   = 1'b0;
        ax_d   = ax_q;
        ay_d   = ay_q;
        az_d   = az_q;
        sx_d   = sx_q;
        sy_d   = sy_q;
        sh_start  = 1'b0;
        launch    = 1'b0;
        tx_st     = st_q;
        tx_idx    = bidx_q + 3'd1;
        last_byte = (st_q == ST_READ) ? 3'd4 : 3'd2;
        if (csn_q && gap_q != GAP_LAST) gap_d = gap_q + GW'(1);
        case (st_q)
            ST_PWRUP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PW_LAST) begin
                    st_d   = ST_WR_FLT;
                    tx_st  = ST_WR_FLT;
                    launch = 1'b1;
                end
            end
            ST_GAP1: if (idle_ok) begin
                st_d   = ST_WR_PWR;
                tx_st  = ST_WR_PWR;
                launch = 1'b1;
            end
            ST_GAP2: if (idle_ok) begin
                st_d  = ST_WAIT;
                cfg_d = 1'b1;
                cnt_d = SP_LAST;
            end
            // counter saturates at terminal value until HOLD and gap allow
            ST_WAIT: begin
                if (cnt_q != SP_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!HOLD && idle_ok) begin
                    st_d   = ST_READ;
                    tx_st  = ST_READ;
                    launch = 1'b1;
                    cnt_d  = '0;
                end
            end
            ST_WR_FLT, ST_WR_PWR, ST_READ: begin
                if (st_q == ST_READ && cnt_q != SP_LAST) cnt_d = cnt_q + CW'(1);
                if (!tail_q) begin
                    if (sh_done) begin
                        if (st_q == ST_READ && bidx_q == 3'd2) sx_d = sh_rx;
                        if (st_q == ST_READ && bidx_q == 3'd3) sy_d = sh_rx;
                        if (bidx_q == last_byte) begin
                            tail_d = 1'b1;
                            tcnt_d = 8'd0;
                        end else begin
                            bidx_d   = bidx_q + 3'd1;
                            sh_start = 1'b1;
                        end
                    end
                end else if (tcnt_q != DIV_LAST) begin
                    tcnt_d = tcnt_q + 8'd1;
                end else begin
                    csn_d  = 1'b1;
                    gap_d  = '0;
                    tail_d = 1'b0;
                    if (st_q == ST_WR_FLT) begin
                        st_d = ST_GAP1;
                    end else if (st_q == ST_WR_PWR) begin
                        st_d = ST_GAP2;
                    end else begin
                        st_d = ST_WAIT;
                        ax_d = sx_q;
                        ay_d = sy_q;
                        az_d = sh_rx;
                        dv_d = 1'b1;
                    end
                end
            end
            default: st_d = ST_PWRUP;
        endcase
        if (launch) begin
            csn_d    = 1'b0;
            bidx_d   = 3'd0;
            tail_d   = 1'b0;
            sh_start = 1'b1;
            tx_idx   = 3'd0;
        end
        sh_tx = frame_byte(tx_st, tx_idx);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q   <= ST_PWRUP;
            cnt_q  <= '0;
            gap_q  <= '0;
            bidx_q <= 3'd0;
            tail_q <= 1'b0;
            tcnt_q <= 8'd0;
            csn_q  <= 1'b1;
            cfg_q  <= 1'b0;
            dv_q   <= 1'b0;
            ax_q   <= 8'd0;
            ay_q   <= 8'd0;
            az_q   <= 8'd0;
            sx_q   <= 8'd0;
            sy_q   <= 8'd0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            gap_q  <= gap_d;
            bidx_q <= bidx_d;
            tail_q <= tail_d;
            tcnt_q <= tcnt_d;
            csn_q  <= csn_d;
            cfg_q  <= cfg_d;
            dv_q   <= dv_d;
            ax_q   <= ax_d;
            ay_q   <= ay_d;
            az_q   <= az_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
        end
    end

    spi_byte_shifter #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shifter (
        .clk  (CLK),
        .rst_n(RST_N),
        .start(sh_start),
        .tx   (sh_tx),
        .miso (ACL_MISO),
        .busy (sh_busy),
        .done (sh_done),
        .rx   (sh_rx),
        .sclk (ACL_SCLK),
        .mosi (ACL_MOSI)
    );

    assign ACL_CSN    = csn_q;
    assign ACC_X      = ax_q;
    assign ACC_Y      = ay_q;
    assign ACC_Z      = az_q;
    assign DATA_VALID = dv_q;
    assign CFG_DONE   = cfg_q;

endmodule

// File: tb/tb_acl_spi_ctrl.sv
// Directed bench for acl_spi_ctrl with an ADXL362 sensor model,
// MOSI byte decoder and a per-cycle SPI framing monitor.
module tb_acl_spi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       acl_miso = 1'b0;
    logic       acl_sclk, acl_mosi, acl_csn;
    logic [7:0] acc_x, acc_y, acc_z;
    logic       dv, cfg_done;

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [39:0] resp = 40'd0;
    logic [7:0]  mbytes[$];
    int          nbits = 0;
    int          last_rises = 0;
    logic [7:0]  sh = 8'd0;

    int   falls[$];
    int   last_rise = 0;
    bit   have_rise = 0;
    int   dv_cnt = 0;
    logic p_sclk = 0, p_mosi = 0, p_csn = 1, p_dv = 0;
    bit   from_fall = 0;
    int   run = 0;

    // sensor bytes X,Y,Z per burst and their hand-decoded signed values
    logic [23:0] dat [6] = '{24'h05FB40, 24'h807F00, 24'hFF01AA,
                             24'h123456, 24'hC33C99, 24'h7E81FE};
    int ex [6] = '{5, -128, -1, 18, -61, 126};
    int ey [6] = '{-5, 127, 1, 52, 60, -127};
    int ez [6] = '{64, 0, -86, 86, -103, -2};
    logic [7:0] exp_cfg [6] = '{8'h0A, 8'h2C, 8'h13, 8'h0A, 8'h2D, 8'h02};
    logic [7:0] exp_rd [5] = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};

    acl_spi_ctrl #(
        .SCLK_DIV     (2),
        .PWRUP_CYCLES (20),
        .SAMPLE_PERIOD(200),
        .CS_GAP       (4)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .HOLD      (hold),
        .ACL_MISO  (acl_miso),
        .ACL_SCLK  (acl_sclk),
        .ACL_MOSI  (acl_mosi),
        .ACL_CSN   (acl_csn),
        .ACC_X     (acc_x),
        .ACC_Y     (acc_y),
        .ACC_Z     (acc_z),
        .DATA_VALID(dv),
        .CFG_DONE  (cfg_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] popb();
        if (mbytes.size() == 0) return 8'hEE;
        return mbytes.pop_front();
    endfunction

    // sensor: shifts resp out on SCLK falls, decodes MOSI on SCLK rises
    always @(posedge acl_csn or posedge acl_sclk or negedge acl_sclk) begin
        if (acl_csn) begin
            last_rises = nbits;
            nbits = 0;
            acl_miso = resp[39];
        end else if (acl_sclk) begin
            sh = {sh[6:0], acl_mosi};
            nbits++;
            if (nbits % 8 == 0) mbytes.push_back(sh);
        end else begin
            acl_miso = (nbits < 40) ? resp[39 - nbits] : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            p_sclk = 0; p_mosi = 0; p_csn = 1; p_dv = 0;
            from_fall = 0; run = 0; have_rise = 0;
        end else begin
            if (p_sclk && acl_sclk) begin
                chk("mosi_stable_hi", acl_mosi, p_mosi);
                chk("csn_stable_hi", acl_csn, p_csn);
            end
            if (acl_sclk != p_sclk) begin
                if (p_sclk || from_fall) chk("sclk_half", run, 2);
                from_fall = !acl_sclk;
                run = 1;
            end else begin
                run++;
            end
            if (p_csn && !acl_csn) begin
                falls.push_back(cyc);
                from_fall = 1;
                run = 1;
                if (have_rise) chk("cs_gap_ge4", 32'((cyc - last_rise) >= 4), 1);
            end
            if (!p_csn && acl_csn) begin
                last_rise = cyc;
                have_rise = 1;
                from_fall = 0;
            end
            if (dv) begin
                dv_cnt++;
                chk("dv_at_csn_rise", {30'd0, p_csn, acl_csn}, 2'b01);
            end
            if (p_dv) chk("dv_one_cycle", dv, 0);
            p_sclk = acl_sclk; p_mosi = acl_mosi;
            p_csn = acl_csn; p_dv = dv;
        end
    end

    task automatic wait_pwrup();
        int n = 0;
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!acl_csn) ok = 1;
        end
        chk("pwrup_cycles", n, 20);
    endtask

    task automatic wait_cfg();
        for (int i = 0; i < 1000 && !cfg_done; i++) @(negedge clk);
        chk("cfg_done_seen", cfg_done, 1);
        chk("cfg_after_csn_rise", 32'(cyc > last_rise), 1);
        for (int i = 0; i < 6; i++) chk("cfg_mosi_byte", popb(), exp_cfg[i]);
    endtask

    task automatic wait_dv();
        for (int i = 0; i < 400 && !dv; i++) @(negedge clk);
        chk("dv_seen", dv, 1);
    endtask

    task automatic check_burst(input int b);
        chk("acc_x", 32'($signed(acc_x)), ex[b]);
        chk("acc_y", 32'($signed(acc_y)), ey[b]);
        chk("acc_z", 32'($signed(acc_z)), ez[b]);
        chk("sclk_rises", last_rises, 40);
        for (int i = 0; i < 5; i++) chk("rd_mosi_byte", popb(), exp_rd[i]);
    endtask

    initial begin
        int base, f5, n0, c, snap;
        rst_n = 1'b1;
        hold = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_csn", acl_csn, 1);
        chk("rst_sclk", acl_sclk, 0);
        chk("rst_mosi", acl_mosi, 0);
        chk("rst_acc_x", acc_x, 0);
        chk("rst_acc_y", acc_y, 0);
        chk("rst_acc_z", acc_z, 0);
        chk("rst_dv", dv, 0);
        chk("rst_cfg", cfg_done, 0);
        rst_n = 1'b1;
        wait_pwrup();
        wait_cfg();

        resp = {16'h0000, dat[0]};
        base = falls.size();
        for (int b = 0; b < 5; b++) begin
            wait_dv();
            check_burst(b);
            resp = {16'h0000, dat[b + 1]};
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            chk("read_period", falls[base + i + 1] - falls[base + i], 200);

        f5 = falls[base + 4];
        while (cyc < f5 + 190) @(negedge clk);
        hold = 1'b1;
        n0 = falls.size();
        repeat (50) @(negedge clk);
        chk("hold_no_fall", falls.size(), n0);
        hold = 1'b0;
        c = cyc;
        for (int i = 0; i < 50 && falls.size() <= n0; i++) @(negedge clk);
        chk("hold_release_lat", falls[n0] - c, 1);

        repeat (10) @(negedge clk);
        hold = 1'b1;
        wait_dv();
        check_burst(5);
        hold = 1'b0;

        n0 = falls.size();
        for (int i = 0; i < 300 && falls.size() <= n0; i++) @(negedge clk);
        chk("burst7_started", 32'(falls.size() > n0), 1);
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_csn", acl_csn, 1);
        chk("midrst_sclk", acl_sclk, 0);
        chk("midrst_acc_x", acc_x, 0);
        chk("midrst_acc_y", acc_y, 0);
        chk("midrst_acc_z", acc_z, 0);
        chk("midrst_cfg", cfg_done, 0);
        repeat (3) @(negedge clk);
        mbytes.delete();
        snap = dv_cnt;
        rst_n = 1'b1;
        wait_pwrup();
        wait_cfg();
        chk("no_stale_dv", dv_cnt, snap);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
